// File: rtl/am_tc_pkg.sv
// ---------------------------------------------------------------------------
// am_tc_pkg : shared encodings and default thresholds for the AM time-code
//             receive path.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package am_tc_pkg;

    localparam int MAG_W      = 8;
    localparam int NOM_HI_MAG = 160;
    localparam int NOM_LO_MAG = 127;

    // Low-interval boundaries in sample ticks for the 0.2/0.5/0.8 s symbols.
    localparam int ZERO_MIN_TICKS = 192308;
    localparam int ZERO_MAX_TICKS = 673077;
    localparam int ONE_MAX_TICKS  = 1442308;
    localparam int MARK_MAX_TICKS = 2403846;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_ONE  = 2'd1,
        SYM_MARK = 2'd2,
        SYM_ERR  = 2'd3
    } sym_e;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } dec_state_e;

    function automatic sym_e classify(input logic [31:0] cnt,
                                      input logic [31:0] zmin,
                                      input logic [31:0] zmax,
                                      input logic [31:0] omax);
        if (cnt < zmin)      return SYM_ERR;
        else if (cnt < zmax) return SYM_ZERO;
        else if (cnt < omax) return SYM_ONE;
        else                 return SYM_MARK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/am_env_slicer.sv
// ---------------------------------------------------------------------------
// am_env_slicer : hysteresis slicer for the envelope magnitude, with optional
//                 run-length deglitch (AM_DEGLITCH_EN).
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module am_env_slicer
    import am_tc_pkg::*;
#(
    parameter int MAG_W    = am_tc_pkg::MAG_W,
    parameter int TH_HI    = 144,
    parameter int TH_LO    = 136,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             sample_valid_i,
    input  logic [MAG_W-1:0] mag_i,
    output logic             low_o,
    output logic             low_next_o,
    output logic             chg_o
);

    localparam logic [MAG_W-1:0] c_TH_HI = MAG_W'(TH_HI);
    localparam logic [MAG_W-1:0] c_TH_LO = MAG_W'(TH_LO);

    logic low_q, low_d;
    logic w_raw_low;

    // Threshold depends on the current level: that is the hysteresis.
    always_comb begin
        w_raw_low = low_q ? (mag_i < c_TH_HI) : (mag_i < c_TH_LO);
    end

`ifdef AM_DEGLITCH_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [FW-1:0] agree_q, agree_d;

    always_comb begin
        low_d   = low_q;
        agree_d = agree_q;
        if (sample_valid_i) begin
            if (w_raw_low != low_q) begin
                if (agree_q == FW'(FILT_LEN - 1)) begin
                    low_d   = w_raw_low;
                    agree_d = '0;
                end else begin
                    agree_d = agree_q + 1'b1;
                end
            end else begin
                agree_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            agree_q <= '0;
        end else begin
            agree_q <= agree_d;
        end
    end
`else
    always_comb begin
        low_d = sample_valid_i ? w_raw_low : low_q;
    end
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            low_q <= 1'b0;
        end else begin
            low_q <= low_d;
        end
    end

    assign low_o      = low_q;
    assign low_next_o = low_d;
    assign chg_o      = (low_d != low_q);

endmodule

`default_nettype wire

// File: rtl/am_symbol_decoder.sv
// ---------------------------------------------------------------------------
// am_symbol_decoder : times low-carrier intervals and classifies them as
//                     ZERO/ONE/MARK/ERR. Optional deglitch: AM_DEGLITCH_EN.
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module am_symbol_decoder
    import am_tc_pkg::*;
#(
    parameter int MAG_W    = am_tc_pkg::MAG_W,
    parameter int TH_HI    = 144,
    parameter int TH_LO    = 136,
    parameter int CNT_W    = 22,
    parameter int ZERO_MIN = ZERO_MIN_TICKS,
    parameter int ZERO_MAX = ZERO_MAX_TICKS,
    parameter int ONE_MAX  = ONE_MAX_TICKS,
    parameter int MARK_MAX = MARK_MAX_TICKS,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             sample_valid,
    input  logic [MAG_W-1:0] mag,
    output logic             carrier_low,
    output logic             sym_valid,
    output logic [1:0]       sym,
    output logic [5:0]       sym_index,
    output logic             frame_sync,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] c_MARK_MAX = CNT_W'(MARK_MAX);

    logic w_low, w_chg;

    am_env_slicer #(
        .MAG_W    (MAG_W),
        .TH_HI    (TH_HI),
        .TH_LO    (TH_LO),
        .FILT_LEN (FILT_LEN)
    ) u_slicer (
        .clk            (clk),
        .areset         (areset),
        .sample_valid_i (sample_valid),
        .mag_i          (mag),
        .low_o          (carrier_low),
        .low_next_o     (w_low),
        .chg_o          (w_chg)
    );

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, w_cnt_inc;
    logic             sym_valid_q, sym_valid_d;
    sym_e             sym_q, sym_d, w_class, w_emit_sym;
    logic             w_emit;
    logic [5:0]       idx_rep_q, idx_rep_d, idx_q, idx_d;
    logic             fsync_q, fsync_d;
    logic [7:0]       err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sym_valid_d = 1'b0;
        sym_d       = sym_q;
        idx_rep_d   = idx_rep_q;
        idx_d       = idx_q;
        fsync_d     = fsync_q;
        err_d       = err_q;
        w_emit      = 1'b0;
        w_emit_sym  = SYM_ERR;
        w_cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        w_class     = classify(32'(cnt_q), 32'(ZERO_MIN), 32'(ZERO_MAX), 32'(ONE_MAX));

        if (sample_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (!w_low) state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    if (w_chg) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_chg) begin
                        w_emit     = 1'b1;
                        w_emit_sym = w_class;
                        state_d    = ST_HIGH;
                    end else begin
                        cnt_d = w_cnt_inc;
                        // Timeout only while still low, so it never collides with a rise.
                        if (w_cnt_inc > c_MARK_MAX) begin
                            w_emit     = 1'b1;
                            w_emit_sym = SYM_ERR;
                            state_d    = ST_STUCK;
                        end
                    end
                end
                ST_STUCK: begin
                    if (!w_low) state_d = ST_HIGH;
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (w_emit) begin
            sym_valid_d = 1'b1;
            sym_d       = w_emit_sym;
            unique case (w_emit_sym)
                SYM_MARK: begin
                    idx_rep_d = 6'd0;
                    idx_d     = 6'd1;
                    fsync_d   = 1'b1;
                end
                SYM_ERR: begin
                    idx_rep_d = 6'd63;
                    idx_d     = 6'd63;
                    fsync_d   = 1'b0;
                    err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                end
                default: begin
                    idx_rep_d = idx_q;
                    idx_d     = (idx_q == 6'd63) ? idx_q : idx_q + 6'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_HUNT;
            cnt_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_q       <= SYM_ZERO;
            idx_rep_q   <= 6'd0;
            idx_q       <= 6'd0;
            fsync_q     <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sym_valid_q <= sym_valid_d;
            sym_q       <= sym_d;
            idx_rep_q   <= idx_rep_d;
            idx_q       <= idx_d;
            fsync_q     <= fsync_d;
            err_q       <= err_d;
        end
    end

    assign sym_valid  = sym_valid_q;
    assign sym        = sym_q;
    assign sym_index  = idx_rep_q;
    assign frame_sync = fsync_q;
    assign err_cnt    = err_q;

endmodule

`default_nettype wire

// File: doc/am_symbol_decoder.md
Name: am_symbol_decoder

Overview:
- Receive-side counterpart of the amplitude-keyed time-code modulator.
- Slices a sampled carrier-envelope magnitude into high/low and times each low-carrier interval in sample ticks.
- Classifies each interval as ZERO (0.2 s low), ONE (0.5 s low) or MARK (0.8 s low), and tracks the symbol position after each MARK.
- Sits after the envelope detector, in the same clock domain as the sample strobe; feeds the status LEDs and the USB readback path.

Parameters:
- MAG_W, 8, envelope magnitude width.
- TH_HI, 144, slicer rises to high when mag >= TH_HI.
- TH_LO, 136, slicer falls to low when mag < TH_LO. TH_LO <= TH_HI is required.
- CNT_W, 22, low-interval tick counter width.
- ZERO_MIN, 192308, shortest valid low interval, in ticks.
- ZERO_MAX, 673077, ZERO when ZERO_MIN <= count < ZERO_MAX.
- ONE_MAX, 1442308, ONE when ZERO_MAX <= count < ONE_MAX.
- MARK_MAX, 2403846, MARK when ONE_MAX <= count <= MARK_MAX; above this is a timeout.
- FILT_LEN, 4, deglitch depth in samples (used only with AM_DEGLITCH_EN).

Ports:
- clk  in  1  system clock.
- areset  in  1  asynchronous reset, active-high.
- sample_valid  in  1  one-clk strobe; mag is valid this cycle.
- mag  in  MAG_W  unsigned envelope magnitude.
- carrier_low  out  1  registered slicer output (1 = low carrier).
- sym_valid  out  1  one-clk pulse; sym and sym_index are valid this cycle.
- sym  out  2  0 = ZERO, 1 = ONE, 2 = MARK, 3 = ERR.
- sym_index  out  6  symbol position since the last MARK (MARK itself reports 0).
- frame_sync  out  1  set on MARK; cleared on ERR.
- err_cnt  out  8  saturating count of ERR symbols.

Behaviour:
- Reset (async, areset=1): all outputs 0; internal counter 0; FSM in HUNT; slicer state = high (carrier_low=0).
- Clocking: all state advances only on clk cycles with sample_valid=1. Cycles without the strobe hold all state; sym_valid is 0 on them.
- Slicer hysteresis:
  - When high, goes low if mag < TH_LO.
  - When low, goes high if mag >= TH_HI.
  - Otherwise holds.
- FSM states:
  - HUNT: ignore lows; go to HIGH on the first sample that slices high. This prevents decoding a partial interval after reset.
  - HIGH: on the first low sample, count <= 1 and go to LOW.
  - LOW:
    - While low, count increments on each strobe.
    - On the first high sample, classify count, emit the symbol, return to HIGH.
    - If count exceeds MARK_MAX while still low, emit ERR once and go to STUCK.
  - STUCK: wait for a high sample, then go to HIGH; no emission on exit.
- Counter saturates at 2^CNT_W-1 and never wraps.
- Classification: count < ZERO_MIN gives ERR (glitch); ranges otherwise as given in Parameters.
- Emission timing: sym_valid, sym, sym_index and frame_sync update on the clk edge that samples the terminating strobe. That is 1 clk of latency from the strobe, plus FILT_LEN-1 strobes when the deglitch is compiled in.
- sym_index:
  - MARK: reported as 0; the register is then set to 1 for the next symbol.
  - ZERO/ONE: reported, then incremented, saturating at 63.
  - ERR: reported as 63; the register is forced to 63.
- frame_sync: set by MARK, cleared by ERR, unchanged by ZERO/ONE.
- err_cnt: increments per ERR; saturates at 255.
- Reset mid-interval: discards count, returns to HUNT, emits nothing.
- A high/low transition and a timeout never occur on the same strobe: timeout is evaluated only while the sample slices low.

Optional Feature:
- Macro: AM_DEGLITCH_EN.
- Defined: the slicer output changes only after FILT_LEN consecutive strobed samples agree on the new level. A shorter run leaves the output unchanged and resets the agreement counter.
- Undefined: the hysteresis output is used directly; FILT_LEN is ignored.

Decomposition:
- Shared package am_tc_pkg holds:
  - symbol encodings SYM_ZERO/SYM_ONE/SYM_MARK/SYM_ERR;
  - default tick thresholds, derived from the modulator's 0.2/0.5/0.8 s durations;
  - MAG_W;
  - the nominal high/low magnitudes 160/127.
- One sub-module, am_env_slicer: hysteresis comparator plus the optional deglitch. Outputs the registered level and a one-clk "level changed" strobe aligned to sample_valid.

Test Plan (scaled parameters: ZERO_MIN=4, ZERO_MAX=14, ONE_MAX=30, MARK_MAX=48, strobe every clk):
1. Reset, then mag=160 ×5, 127 ×40, 160 ×10 -> one sym_valid: sym=2, sym_index=0, frame_sync=1.
2. After a MARK: low 10 then high, low 25 then high -> sym=0 idx=1, then sym=1 idx=2; err_cnt=0.
3. Low 2 samples then high -> sym=3, sym_index=63, frame_sync=0, err_cnt=1.
4. Hold low 60 samples -> exactly one ERR at count 49; no emission on the later rise.
5. mag oscillating 138/142 while high -> no falling transition (hysteresis). With AM_DEGLITCH_EN, three-sample low bursts are ignored.
6. Assert areset mid-LOW at count 20 -> outputs cleared. A subsequent low-then-high yields no symbol until a high has been seen first (HUNT).
